// File: rtl/phy_reg_free_list_pkg.sv
// Shared types and sizing for the physical register free list.
package phy_reg_free_list_pkg;

    localparam int NUM_ARCH_REGS   = 32;
    localparam int NUM_PHYS_REGS   = 128;
    localparam int FREE_LIST_DEPTH = 128;

    // Registers not holding an architectural mapping at reset are the free pool.
    localparam int NUM_FREE_REGS   = NUM_PHYS_REGS - NUM_ARCH_REGS;

    // Physical register id: msb is a valid bit, low 7 bits select the register.
    typedef logic [7:0] PhyRegisterId_T;

    // Ring pointer: 7 index bits plus a wrap bit.
    typedef logic [7:0] FreeListPtr_T;

    // Speculative free count, 0..96.
    typedef logic [6:0] FreeCount_T;

    // Ring slot selected by a pointer (the wrap bit is dropped).
    function automatic logic [6:0] ptr_index(input FreeListPtr_T ptr);
        return ptr[6:0];
    endfunction

endpackage

// File: rtl/phy_reg_free_list.sv
// Physical register free list for the rename stage.
// Speculative head hands out ids, commit_head tracks the oldest retired
// allocation, tail receives stale mappings returned at retirement. A flush
// rewinds head to commit_head, returning every uncommitted id to the pool.
module phy_reg_free_list
    import phy_reg_free_list_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           alloc_req,
    output logic           alloc_ready,
    output PhyRegisterId_T alloc_id,
    input  logic           alloc_commit,
    input  logic           free_valid,
    input  PhyRegisterId_T free_id,
    input  logic           flush,
    output logic [6:0]     free_count,
    output logic           err
);

    logic [6:0]   ring [FREE_LIST_DEPTH];
    FreeListPtr_T head;
    FreeListPtr_T commit_head;
    FreeListPtr_T tail;
    FreeCount_T   count_q;
    logic         err_q;

    logic         alloc_fire;
    logic         free_req;
    logic         free_drop;
    logic         free_fire;
    logic         commit_bad;
    logic         commit_fire;
    FreeListPtr_T commit_next;
    FreeListPtr_T tail_next;
    FreeListPtr_T head_next;
    FreeListPtr_T flush_span;
    FreeCount_T   count_next;

    // Handshake and next-state decisions; outputs depend only on registered state and flush.
    always_comb begin
        alloc_ready = (count_q != '0) && !flush;
        alloc_id    = alloc_ready ? {1'b1, ring[ptr_index(head)]} : '0;
        alloc_fire  = alloc_req && alloc_ready;

        // A free is only refused when the pool is full and nothing leaves it this cycle.
        free_req    = free_valid && free_id[7];
        free_drop   = free_req && !alloc_fire && (count_q == FreeCount_T'(NUM_FREE_REGS));
        free_fire   = free_req && !free_drop;

        commit_bad  = alloc_commit && (commit_head == head);
        commit_fire = alloc_commit && !commit_bad;

        commit_next = commit_head + {7'd0, commit_fire};
        tail_next   = tail + {7'd0, free_fire};
        flush_span  = tail_next - commit_next;

        if (flush) begin
            head_next  = commit_next;
            count_next = flush_span[6:0];
        end else begin
            head_next  = head + {7'd0, alloc_fire};
            count_next = count_q + {6'd0, free_fire} - {6'd0, alloc_fire};
        end
    end

    // Ring storage: reset preloads the free pool ids 32..127, frees append at tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
                ring[i] <= (i < NUM_FREE_REGS) ? 7'(NUM_ARCH_REGS + i) : 7'd0;
            end
        end else if (free_fire) begin
            ring[ptr_index(tail)] <= free_id[6:0];
        end
    end

    // Pointers, speculative count and the sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= FreeListPtr_T'(NUM_FREE_REGS);
            count_q     <= FreeCount_T'(NUM_FREE_REGS);
            err_q       <= 1'b0;
        end else begin
            head        <= head_next;
            commit_head <= commit_next;
            tail        <= tail_next;
            count_q     <= count_next;
            if (free_drop || commit_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign free_count = count_q;
    assign err        = err_q;

endmodule

// File: doc/phy_reg_free_list.md
PHY_REG_FREE_LIST -- requirements
Module: phy_reg_free_list

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; one clock domain only.
REQ-002 SHALL have port rst input 1, asynchronous, active-high reset.
REQ-003 SHALL have port alloc_req input 1, rename stage requests one physical register this cycle.
REQ-004 SHALL have port alloc_ready output 1, a free register is available and allocation is permitted.
REQ-005 SHALL have port alloc_id output PhyRegisterId_T (8), head entry; msb = valid bit.
REQ-006 SHALL have port alloc_commit input 1, oldest outstanding allocation retired.
REQ-007 SHALL have port free_valid input 1, with free_id input PhyRegisterId_T (8): retired stale mapping returned.
REQ-008 SHALL have port flush input 1, pipeline squash; discard all uncommitted allocations.
REQ-009 SHALL have port free_count output 7, number of speculatively free registers, 0..96.
REQ-010 SHALL have port err output 1, sticky protocol-violation flag.

Function
REQ-011 Storage SHALL be a 128-entry ring of 7-bit ids; head, commit_head and tail SHALL be 8-bit pointers (7 index bits plus wrap bit).
REQ-012 alloc_ready SHALL equal (free_count != 0) and not flush, from registered state only.
REQ-013 alloc_id SHALL be {1'b1, ring[head]} when alloc_ready, else 8'h00.
REQ-014 Allocation fires on alloc_req && alloc_ready; head SHALL increment at that clock edge; zero-cycle latency from request to id.
REQ-015 alloc_req without alloc_ready SHALL be ignored with no state change.
REQ-016 free_valid with free_id[7]=1 SHALL write free_id[6:0] at ring[tail] and increment tail; free_id[7]=0 SHALL be ignored.
REQ-017 A register freed in cycle N SHALL become allocatable no earlier than cycle N+1; no same-cycle bypass.
REQ-018 Simultaneous allocation and free SHALL leave free_count unchanged.
REQ-019 alloc_commit SHALL increment commit_head; if commit_head equals head (nothing outstanding), it SHALL be ignored and err set.
REQ-020 A free that would make free_count exceed 96 SHALL be dropped and err set.
REQ-021 flush SHALL set head to commit_head (after any same-cycle alloc_commit increment) and free_count to tail - new head (including any same-cycle free).
REQ-022 Pointer and count arithmetic SHALL be modulo 256 pointer / 128 index with wrap bit; wrap from index 127 to 0 SHALL be seamless.
REQ-023 err SHALL remain set until reset.

Reset
REQ-024 On rst: ring[i] = 32+i for i = 0..95, ring[96..127] = 0.
REQ-025 On rst: head = commit_head = 0, tail = 96, free_count = 96, err = 0.
REQ-026 On rst: alloc_ready = 1 and alloc_id = 8'hA0 once rst deasserts; reset mid-operation SHALL discard all state immediately.

Structure
REQ-027 Package Type SHALL gain NUM_ARCH_REGS = 32, NUM_PHYS_REGS = 128, FREE_LIST_DEPTH = 128 and FreeListPtr_T (logic[7:0]).
REQ-028 Block SHALL be a single module with no sub-module; ring is a flop/register-file array with one write and one read port.

Verification
REQ-029 Reset, then alloc_req held 3 cycles -> alloc_id 8'hA0, 8'hA1, 8'hA2; free_count 96 to 93.
REQ-030 Allocate all 96 -> alloc_ready=0, alloc_id=8'h00; free 8'h85 with alloc_req high -> alloc_ready=1 next cycle, alloc_id=8'h85.
REQ-031 Allocate 5, alloc_commit 2, flush -> next alloc_id = {1,ring[2]} = 8'hA2, free_count 94.
REQ-032 Same-cycle alloc_req, free_valid(8'h90) at count 10 -> count stays 10; 8'h90 appears after all 10 earlier ids.
REQ-033 Free at count 96, or alloc_commit with nothing outstanding -> err=1, counts and pointers unchanged.
REQ-034 Cycle 200 allocations plus 200 frees -> pointers wrap past index 127; id order matches reference FIFO model.
